// File: rtl/kin_debounce_latch_if.sv
// rtl/kin_debounce_latch_if.sv - key-input front end signal bundle
interface kin_debounce_latch_if #(
  parameter int WIDTH = 4
);
  logic             ena;
  logic [WIDTH-1:0] kin;
  logic [WIDTH-1:0] flag_clr;
  logic [WIDTH-1:0] kin_stable;
  logic [WIDTH-1:0] kin_flag;
  logic             kin_irq;
  logic             mc_strobe;

  // Board/core side: drives pins, enable and flag clears; reads results
  modport master (
    output ena, kin, flag_clr,
    input  kin_stable, kin_flag, kin_irq, mc_strobe
  );

  // Front end side
  modport slave (
    input  ena, kin, flag_clr,
    output kin_stable, kin_flag, kin_irq, mc_strobe
  );
endinterface

// File: rtl/kin_debounce_latch.sv
// rtl/kin_debounce_latch.sv - key-input synchroniser, per-bit debouncer and sticky edge flags
module kin_debounce_latch #(
  parameter int WIDTH     = 4,
  parameter int CYCLE_LEN = 8,
  parameter int DEBOUNCE  = 3,
  parameter int EDGE_MODE = 2
) (
  input logic                 clk,
  input logic                 rst,
  kin_debounce_latch_if.slave bus
);
  localparam int PW = (CYCLE_LEN > 1) ? $clog2(CYCLE_LEN) : 1;
  localparam int CW = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(CYCLE_LEN - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE - 1);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] flag_q, flag_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] edge_mask;
  logic             strobe;

  // Sample once per machine cycle, on its last enabled clock
  always_comb begin
    strobe = bus.ena && (phase_q == PHASE_LAST);
  end

  // Two-stage synchroniser and machine-cycle phase counter
  always_comb begin
    sync1_d = bus.kin;
    sync2_d = sync1_q;
    phase_d = phase_q;
    if (bus.ena) begin
      phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
    end
  end

  // Per-bit debounce: count consecutive differing samples, accept on the DEBOUNCE-th
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    accept   = '0;
    if (strobe) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2_q[i] == stable_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
          cnt_d[i]    = '0;
          accept[i]   = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Sticky flags: clear first, then a qualifying accepted edge sets (set wins)
  always_comb begin
    edge_mask = '1;
    if (EDGE_MODE == 0) begin
      edge_mask = ~stable_d;
    end else if (EDGE_MODE == 1) begin
      edge_mask = stable_d;
    end
    flag_d = (flag_q & ~bus.flag_clr) | (accept & edge_mask);
  end

  // State registers; reset preloads the pins so already-held keys report no edge
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= bus.kin;
      sync2_q  <= bus.kin;
      stable_q <= bus.kin;
      flag_q   <= '0;
      phase_q  <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      flag_q   <= flag_d;
      phase_q  <= phase_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.kin_stable = stable_q;
  assign bus.kin_flag   = flag_q;
  assign bus.kin_irq    = |flag_q;
  assign bus.mc_strobe  = strobe;
endmodule

// File: tb/tb_kin_debounce_latch.sv
// tb/tb_kin_debounce_latch.sv - randomized reference-model bench for kin_debounce_latch
module tb_kin_debounce_latch;
  localparam int CL0 = 8, DB0 = 3, EM0 = 2;
  localparam int CL1 = 3, DB1 = 2, EM1 = 0;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena_r;
  logic [3:0] kin_r;
  logic [3:0] clr_r;

  int vectors = 0;
  int miscompares = 0;

  kin_debounce_latch_if #(.WIDTH(4)) if0 ();
  kin_debounce_latch_if #(.WIDTH(4)) if1 ();

  assign if0.ena = ena_r;
  assign if0.kin = kin_r;
  assign if0.flag_clr = clr_r;
  assign if1.ena = ena_r;
  assign if1.kin = kin_r;
  assign if1.flag_clr = clr_r;

  kin_debounce_latch #(.WIDTH(4), .CYCLE_LEN(CL0), .DEBOUNCE(DB0), .EDGE_MODE(EM0))
    dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  kin_debounce_latch #(.WIDTH(4), .CYCLE_LEN(CL1), .DEBOUNCE(DB1), .EDGE_MODE(EM1))
    dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  always #5 clk = ~clk;

  // Reference model state: pin history plus, per configuration, a count of
  // enabled clocks, a run length of differing samples, the accepted word and flags
  int         cl [2];
  int         db [2];
  int         em [2];
  int         m_clk [2];
  int         m_run [2][4];
  logic [3:0] m_stab [2];
  logic [3:0] m_flag [2];
  logic [3:0] pin_prev1, pin_prev2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_clk[d] = 0;
        for (int i = 0; i < 4; i++) m_run[d][i] = 0;
        m_flag[d] = 4'b0;
        m_stab[d] = kin_r;
      end else begin
        logic       sample;
        logic [3:0] seen;
        logic [3:0] nflag;
        seen   = pin_prev2;
        sample = ena_r && ((m_clk[d] % cl[d]) == cl[d] - 1);
        if (ena_r) m_clk[d] = m_clk[d] + 1;
        nflag = m_flag[d] & ~clr_r;
        if (sample) begin
          for (int i = 0; i < 4; i++) begin
            if (seen[i] == m_stab[d][i]) begin
              m_run[d][i] = 0;
            end else begin
              m_run[d][i] = m_run[d][i] + 1;
              if (m_run[d][i] >= db[d]) begin
                m_stab[d][i] = seen[i];
                m_run[d][i] = 0;
                if (em[d] == 2 || em[d] == int'(seen[i])) nflag[i] = 1'b1;
              end
            end
          end
        end
        m_flag[d] = nflag;
      end
    end
    if (rst) begin
      pin_prev1 = kin_r;
      pin_prev2 = kin_r;
    end else begin
      pin_prev2 = pin_prev1;
      pin_prev1 = kin_r;
    end
  endtask

  task automatic check_all();
    logic exp_strobe;
    exp_strobe = ena_r && ((m_clk[0] % cl[0]) == cl[0] - 1);
    check("d0.kin_stable", 32'(if0.kin_stable), 32'(m_stab[0]));
    check("d0.kin_flag",   32'(if0.kin_flag),   32'(m_flag[0]));
    check("d0.kin_irq",    32'(if0.kin_irq),    32'(m_flag[0] != 4'b0));
    check("d0.mc_strobe",  32'(if0.mc_strobe),  32'(exp_strobe));
    exp_strobe = ena_r && ((m_clk[1] % cl[1]) == cl[1] - 1);
    check("d1.kin_stable", 32'(if1.kin_stable), 32'(m_stab[1]));
    check("d1.kin_flag",   32'(if1.kin_flag),   32'(m_flag[1]));
    check("d1.kin_irq",    32'(if1.kin_irq),    32'(m_flag[1] != 4'b0));
    check("d1.mc_strobe",  32'(if1.mc_strobe),  32'(exp_strobe));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    @(negedge clk);
  endtask

  typedef struct {
    logic [3:0] kin;
    logic       ena;
    logic [3:0] clr;
    logic       rst;
    int         n;
  } seg_t;

  seg_t dir [14];

  initial begin
    cl = '{CL0, CL1};
    db = '{DB0, DB1};
    em = '{EM0, EM1};
    dir = '{
      '{4'b1010, 1'b0, 4'b0000, 1'b1, 2},
      '{4'b1010, 1'b1, 4'b0000, 1'b0, 20},
      '{4'b1011, 1'b1, 4'b0000, 1'b0, 40},
      '{4'b1001, 1'b1, 4'b0000, 1'b0, 16},
      '{4'b1011, 1'b1, 4'b0000, 1'b0, 24},
      '{4'b1111, 1'b1, 4'b0000, 1'b0, 12},
      '{4'b1111, 1'b0, 4'b0000, 1'b0, 20},
      '{4'b1111, 1'b1, 4'b0000, 1'b0, 30},
      '{4'b1110, 1'b1, 4'b0000, 1'b0, 29},
      '{4'b1111, 1'b1, 4'b0001, 1'b0, 30},
      '{4'b1111, 1'b1, 4'b1111, 1'b0, 2},
      '{4'b0100, 1'b1, 4'b0000, 1'b0, 12},
      '{4'b0110, 1'b1, 4'b0000, 1'b1, 1},
      '{4'b0110, 1'b1, 4'b0000, 1'b0, 40}
    };
    rst   = 1'b1;
    ena_r = 1'b0;
    kin_r = 4'b1010;
    clr_r = 4'b0;
    for (int s = 0; s < 14; s++) begin
      for (int c = 0; c < dir[s].n; c++) begin
        kin_r = dir[s].kin;
        ena_r = dir[s].ena;
        clr_r = dir[s].clr;
        rst   = dir[s].rst;
        step();
      end
    end
    rst = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 29) == 0) kin_r[$urandom_range(0, 3)] ^= 1'b1;
      if (ena_r) begin
        if ($urandom_range(0, 39) == 0) ena_r = 1'b0;
      end else if ($urandom_range(0, 7) == 0) begin
        ena_r = 1'b1;
      end
      clr_r = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
      rst   = ($urandom_range(0, 799) == 0);
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
